// File: rtl/fetch_unit_rv32i.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit_rv32i                                                         |
// | RV32I fetch stage: owns PC, pairs synchronous-ROM data with its address, |
// | buffers pairs toward decode with credit-based issue and redirect squash. |
// | Optional: define FETCH_PERF_EN for fetch/squash performance counters.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fetch_unit_rv32i #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          BUF_DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] PC,
  input  logic [31:0] INSTR,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        misalign_err
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_squash_cnt
`endif
);

  localparam int c_ptr_w = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(BUF_DEPTH);

  logic [31:0]        r_pc;
  logic [31:0]        r_tag;
  logic               r_inflight;
  logic               r_misalign;
  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_tail;
  logic [c_cnt_w-1:0] r_count;
  logic [31:0]        r_mem_pc    [BUF_DEPTH];
  logic [31:0]        r_mem_instr [BUF_DEPTH];

  logic               w_pop;
  logic               w_push;
  logic               w_issue;
  logic [c_cnt_w-1:0] w_occ;

  // w_occ is the buffer demand after this cycle's pop; it is also the
  // number of entries a redirect throws away.
  always_comb begin
    w_pop   = (r_count != '0) & out_ready;
    w_push  = r_inflight & ~redirect_valid;
    w_occ   = r_count + c_cnt_w'(r_inflight) - c_cnt_w'(w_pop);
    w_issue = ~redirect_valid & (w_occ < c_depth);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_pc       <= RESET_VECTOR;
      r_tag      <= '0;
      r_inflight <= 1'b0;
      r_misalign <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else if (redirect_valid) begin
      r_pc       <= {redirect_pc[31:2], 2'b00};
      r_inflight <= 1'b0;
      r_misalign <= |redirect_pc[1:0];
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      r_misalign <= 1'b0;
      if (w_issue) begin
        r_tag      <= r_pc;
        r_inflight <= 1'b1;
        r_pc       <= r_pc + 32'd4;
      end else begin
        r_inflight <= 1'b0;
      end
      if (w_push) r_tail <= r_tail + c_ptr_w'(1);
      if (w_pop)  r_head <= r_head + c_ptr_w'(1);
      r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    end
  end

  // Storage needs no reset: outputs are gated by the occupancy count.
  always_ff @(posedge clock) begin
    if (reset_n && w_push) begin
      r_mem_pc[r_tail]    <= r_tag;
      r_mem_instr[r_tail] <= INSTR;
    end
  end

  assign PC           = r_pc;
  assign out_valid    = (r_count != '0);
  assign out_pc       = out_valid ? r_mem_pc[r_head]    : 32'd0;
  assign out_instr    = out_valid ? r_mem_instr[r_head] : 32'd0;
  assign misalign_err = r_misalign;

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_squash_cnt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_fetch_cnt  <= '0;
      r_squash_cnt <= '0;
    end else begin
      if (w_issue)        r_fetch_cnt  <= r_fetch_cnt + 32'd1;
      if (redirect_valid) r_squash_cnt <= r_squash_cnt + 32'(w_occ);
    end
  end

  assign perf_fetch_cnt  = r_fetch_cnt;
  assign perf_squash_cnt = r_squash_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit_rv32i.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_unit_rv32i                                                      |
// | Directed scenarios plus random traffic against a queue-based model.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fetch_unit_rv32i;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam int          BUF_DEPTH    = 2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] PC;
  logic [31:0] INSTR;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        misalign_err;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_squash_cnt;
`endif

  fetch_unit_rv32i #(
    .RESET_VECTOR (RESET_VECTOR),
    .BUF_DEPTH    (BUF_DEPTH)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .PC             (PC),
    .INSTR          (INSTR),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .misalign_err   (misalign_err)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_squash_cnt (perf_squash_cnt)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Synchronous-read instruction ROM
  always @(posedge clock) INSTR <= rom_word(PC);

  // Reference model: fetch address, one optional in-flight address, a queue of pairs
  logic [31:0] m_pc;
  logic [31:0] m_tag;
  bit          m_inflight;
  bit          m_mis;
  bit          m_started;
  bit          m_just_reset;
  logic [63:0] m_buf[$];
  logic [31:0] m_fetch;
  logic [31:0] m_squash;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit          pop;
    logic [31:0] a;
    pop = (m_buf.size() > 0) && out_ready;
    if (!reset_n) begin
      m_pc = RESET_VECTOR; m_inflight = 0; m_mis = 0;
      m_buf.delete(); m_fetch = 0; m_squash = 0;
      m_just_reset = 1; m_started = 1;
    end else if (redirect_valid) begin
      if (pop) void'(m_buf.pop_front());
      m_squash = m_squash + 32'(m_buf.size()) + 32'(m_inflight);
      m_buf.delete();
      m_inflight = 0;
      m_pc  = {redirect_pc[31:2], 2'b00};
      m_mis = (redirect_pc[1:0] != 2'b00);
      m_just_reset = 0;
    end else begin
      int demand;
      demand = m_buf.size() + int'(m_inflight) - int'(pop);
      if (pop) void'(m_buf.pop_front());
      if (m_inflight) begin
        a = m_tag;
        m_buf.push_back({a, rom_word(a)});
      end
      if (demand < BUF_DEPTH) begin
        m_tag = m_pc; m_inflight = 1; m_pc = m_pc + 32'd4; m_fetch = m_fetch + 1;
      end else begin
        m_inflight = 0;
      end
      m_mis = 0;
      m_just_reset = 0;
    end
  endtask

  task automatic check_outputs();
    logic [63:0] head;
    chk("PC", PC, m_pc);
    chk("out_valid", 32'(out_valid), 32'(m_buf.size() > 0));
    chk("misalign_err", 32'(misalign_err), 32'(m_mis));
    if (m_buf.size() > 0) begin
      head = m_buf[0];
      chk("out_pc", out_pc, head[63:32]);
      chk("out_instr", out_instr, head[31:0]);
    end else if (m_just_reset) begin
      chk("out_pc_reset", out_pc, 32'd0);
      chk("out_instr_reset", out_instr, 32'd0);
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, m_fetch);
    chk("perf_squash_cnt", perf_squash_cnt, m_squash);
`endif
  endtask

  task automatic step(input bit rn, input bit rdy, input bit rv, input logic [31:0] rpc);
    @(negedge clock);
    if (m_started) check_outputs();
    reset_n        = rn;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clock);
    model_edge();
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b1, rdy, 1'b0, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    m_started = 0; m_just_reset = 0; m_inflight = 0; m_mis = 0;
    m_pc = '0; m_tag = '0; m_fetch = '0; m_squash = '0;

    step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    // Streaming from the reset vector
    run(8, 1'b1);
    // Back-pressure, then resume
    run(5, 1'b0);
    run(4, 1'b1);
    // Redirect while full
    run(3, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0040);
    run(4, 1'b1);
    // Misaligned target
    step(1'b1, 1'b1, 1'b1, 32'h0000_0042);
    run(4, 1'b1);
    // Address wrap
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    run(5, 1'b1);
    // Reset with entries buffered
    run(3, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    run(4, 1'b1);
    // Redirect coinciding with a pop
    run(2, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'h0000_1001);
    run(3, 1'b1);

    for (int i = 0; i < 4000; i++) begin
      bit          rn, rdy, rv;
      logic [31:0] rpc;
      rn  = ($urandom_range(0, 99) != 0);
      rdy = ($urandom_range(0, 99) < 70);
      rv  = ($urandom_range(0, 99) < 6);
      case ($urandom_range(0, 2))
        0:       rpc = $urandom;
        1:       rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: rpc = 32'($urandom_range(0, 255));
      endcase
      step(rn, rdy, rv, rpc);
    end

    @(negedge clock);
    check_outputs();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
